// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile geometry, entry layout, clear FSM states and rotation helper
package tile_pkg;

    localparam int TILE_W    = 8;
    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 30;

    typedef enum logic [1:0] {
        ROT_0,
        ROT_90,
        ROT_180,
        ROT_270
    } rot_e;

    typedef struct packed {
        rot_e       rotation;
        logic [1:0] tile_type;
    } tile_entry_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_CLEAR
    } clr_state_e;

    // Returns {xpos, ypos}; 7-v is the bitwise inverse in 3 bits.
    function automatic logic [5:0] rotate_xy(input rot_e r, input logic [2:0] fx, input logic [2:0] fy);
        case (r)
            ROT_0:   return {fx, fy};
            ROT_90:  return {fy, ~fx};
            ROT_180: return {~fx, ~fy};
            ROT_270: return {~fy, fx};
            default: return {fx, fy};
        endcase
    endfunction

endpackage

// File: rtl/tile_ram.sv
// rtl/tile_ram.sv - single write port, single read port synchronous read-first tile RAM
module tile_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tile_scanner.sv
// rtl/tile_scanner.sv - beam-driven tile RAM scanner feeding the glyph ROM; optional TILE_SCANNER_ROTATE_EN
module tile_scanner
    import tile_pkg::*;
#(
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_on,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    output logic              wr_ack,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [1:0]        tile_type,
    output logic [1:0]        rotation,
    output logic [2:0]        ypos,
    output logic [2:0]        xpos,
    input  logic              rom_bit,
    output logic              pixel,
    output logic              pixel_valid
);

    localparam int FINE_W = $clog2(TILE_W);
    localparam int COL_W  = $clog2(GRID_COLS);
    localparam int ROW_W  = $clog2(GRID_ROWS);

    clr_state_e        clr_state, clr_next;
    logic [ADDR_W-1:0] clr_cnt, cnt_next;
    logic              ram_we, ram_we_g, wr_commit;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [3:0]        ram_wdata, ram_rdata;

    logic              vis, vis_d1, vis_d2;
    logic [FINE_W-1:0] fx_d1, fy_d1;
    tile_entry_t       entry;
    logic [2:0]        x_t, y_t;
    rot_e              rot_t;

    assign vis       = display_on && (hpos < 9'(H_ACTIVE)) && (vpos < 9'(V_ACTIVE));
    assign ram_raddr = ADDR_W'({vpos[FINE_W+ROW_W-1:FINE_W], hpos[FINE_W+COL_W-1:FINE_W]});
    assign clear_busy = (clr_state == CLR_CLEAR);

    // Clear engine owns the write port; CPU writes only land while idle.
    always_comb begin
        clr_next  = clr_state;
        cnt_next  = clr_cnt;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        wr_commit = 1'b0;
        case (clr_state)
            CLR_IDLE: begin
                if (wr_en) begin
                    ram_we    = 1'b1;
                    wr_commit = 1'b1;
                end
                if (clear_req) begin
                    clr_next = CLR_CLEAR;
                    cnt_next = '0;
                end
            end
            CLR_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = '0;
                if (clear_req) begin
                    cnt_next = '0;
                end else if (clr_cnt == '1) begin
                    clr_next = CLR_IDLE;
                    cnt_next = '0;
                end else begin
                    cnt_next = clr_cnt + 1'b1;
                end
            end
            default: clr_next = CLR_CLEAR;
        endcase
    end

    assign ram_we_g = ram_we && reset;

    tile_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (4)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_g),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign entry = tile_entry_t'(ram_rdata);

`ifdef TILE_SCANNER_ROTATE_EN
    assign {x_t, y_t} = rotate_xy(entry.rotation, fx_d1, fy_d1);
    assign rot_t      = entry.rotation;
`else
    logic unused_rot;
    assign unused_rot = ^entry.rotation;
    assign x_t        = fx_d1;
    assign y_t        = fy_d1;
    assign rot_t      = ROT_0;
`endif

    always_ff @(posedge clk) begin
        fx_d1 <= hpos[FINE_W-1:0];
        fy_d1 <= vpos[FINE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_state   <= CLR_CLEAR;
            clr_cnt     <= '0;
            wr_ack      <= 1'b0;
            vis_d1      <= 1'b0;
            vis_d2      <= 1'b0;
            tile_type   <= '0;
            rotation    <= '0;
            xpos        <= '0;
            ypos        <= '0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            clr_state   <= clr_next;
            clr_cnt     <= cnt_next;
            wr_ack      <= wr_commit;
            vis_d1      <= vis;
            vis_d2      <= vis_d1;
            tile_type   <= entry.tile_type;
            rotation    <= rot_t;
            xpos        <= x_t;
            ypos        <= y_t;
            pixel       <= rom_bit && vis_d2;
            pixel_valid <= vis_d2;
        end
    end

endmodule

// File: doc/tile_scanner.md
Name: tile_scanner

Overview:
- Raster-side initiator for the 8x8 tile glyph ROM.
- Holds a 32x32-entry tile RAM; each entry is {rotation[1:0], tile_type[1:0]}.
- Walks the beam position from the hvsync generator and drives tile_type/rotation/ypos/xpos to the glyph ROM, applying rotation to the in-tile coordinates.
- Registers the returned ROM bit as the pixel. Also provides a CPU write port and a hardware tile-RAM clear engine.

Parameters:
- H_ACTIVE, 256, visible columns (multiple of 8, max 256)
- V_ACTIVE, 240, visible rows (multiple of 8, max 256)
- ADDR_W, 10, tile RAM address width ({row[4:0], col[4:0]})

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- display_on  in  1  beam inside active video
- hpos  in  9  beam column
- vpos  in  9  beam row
- wr_en  in  1  CPU tile write request
- wr_addr  in  ADDR_W  {row, col}
- wr_data  in  4  {rotation, tile_type}
- wr_ack  out  1  one-cycle pulse: previous-cycle write committed
- clear_req  in  1  start a full tile-RAM clear
- clear_busy  out  1  clear engine running
- tile_type  out  2  glyph ROM tile select
- rotation  out  2  rotation code forwarded to ROM
- ypos  out  3  ROM row (post-transform)
- xpos  out  3  ROM column (post-transform)
- rom_bit  in  1  combinational ROM pixel for the current tile_type/ypos/xpos
- pixel  out  1  registered pixel
- pixel_valid  out  1  pixel belongs to the visible tile area

Behaviour:
- Reset (reset==0 at a clk edge):
  - pixel, pixel_valid, tile_type, rotation, ypos, xpos and wr_ack are 0.
  - Clear FSM forced to CLEAR with counter 0, so clear_busy=1.
  - Reset asserted mid-clear restarts the clear from 0.
- Visible: vis = display_on && hpos<H_ACTIVE && vpos<V_ACTIVE.
- Read address: {vpos[7:3], hpos[7:3]}.
- Pipeline, for inputs sampled at edge k:
  - k: tile RAM synchronous read; vis and fine coords hpos[2:0], vpos[2:0] registered.
  - k+1: ROM outputs registered from RAM data and the transformed coords.
  - k+2: pixel<=rom_bit&vis_d2; pixel_valid<=vis_d2.
  - Total latency is 2 cycles.
  - When not visible, the ROM outputs still update, but pixel is 0.
- Rotation transform (fx,fy = fine coords):
  - 0: (fx, fy)
  - 1: (fy, 7-fx)
  - 2: (7-fx, 7-fy)
  - 3: (7-fy, fx)
  - Output as xpos, ypos.
  - All arithmetic is 3-bit; 7-v is implemented as ~v.
- Tile RAM:
  - 1024x4, one write port and one read port.
  - Read-first: a simultaneous read and write to the same address returns the old data.
- Write arbitration:
  - CLEAR owns the write port.
  - wr_en during clear_busy is dropped and wr_ack stays 0.
  - Otherwise the write commits at the edge and wr_ack=1 on the following cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req (counter <= 0).
  - In CLEAR, write 0 to address counter each cycle.
  - At counter==1023, write the entry and go to IDLE; the counter wraps to 0.
  - A clear takes 1024 cycles after entry.
  - clear_req while in CLEAR restarts the counter at 0.
  - clear_busy = (state==CLEAR).
- Scanning never stalls. Reads during CLEAR return a mix of old data and zeros.
- Rows >= 30 and columns >= 32 are addressable by writes but not displayed with the defaults.

Optional Feature:
- Macro TILE_SCANNER_ROTATE_EN.
- Defined: transform applied as above; rotation output = stored rotation.
- Undefined: xpos/ypos = fx/fy untransformed; rotation output tied to 0; stored rotation bits are still written and read but ignored.

Decomposition:
- Shared package tile_pkg:
  - TILE_W=8, GRID_COLS=32, GRID_ROWS=30
  - rot_e enum (ROT_0, ROT_90, ROT_180, ROT_270)
  - tile_entry_t packed struct {rot_e rotation; logic [1:0] tile_type}
  - clear FSM state enum
- One sub-module, tile_ram: 1024x4 synchronous read-first RAM.
- Write mux and clear FSM live in tile_scanner.

Test Plan:
- Reset low 1 cycle then high:
  - clear_busy=1 for exactly 1024 cycles, then 0.
  - All outputs 0 after reset.
  - Read any address -> 0.
- Write addr 0x021 data 4'b0001 (type1, rot0) with no clear running; next cycle wr_ack=1.
- Scan hpos=8..15, vpos=8:
  - ROM outputs tile_type=1, ypos=0, xpos=0..7, two cycles after each input.
  - pixel follows rom_bit (model ROM: row 0 of type 1 = 00010000) -> pixel=1 only at hpos=11.
- Entry 4'b0110 (type2, rot1) at hpos fine 2, vpos fine 5 -> xpos=5, ypos=5, rotation=1.
  - Without TILE_SCANNER_ROTATE_EN -> xpos=2, ypos=5, rotation=0.
- clear_req at cycle 0, wr_en at cycle 10:
  - Write dropped, wr_ack stays 0.
  - clear_req at cycle 500 -> busy until cycle 500+1024.
- Same-cycle write and read of addr 0x000 -> read returns old value; new value visible on the next read.
- hpos=256 or display_on=0 -> pixel_valid=0 and pixel=0 two cycles later.
